// File: rtl/cnn_layer_accel_weight_sequence_gen.sv
// Weight sequence generator: walks a Gray-coded phase and an entry index over
// the weight sequence table num_repeat times per start command. It emits an
// issue strobe for every real lookup and a valid strobe delayed by the table
// latency, and hands completion back to the layer controller with busy/done.
module cnn_layer_accel_weight_sequence_gen #(
  parameter int C_SEQ_LEN        = 5,
  parameter int C_SEQ_ADDR_WIDTH = 3,
  parameter int C_RPT_WIDTH      = 8,
  parameter int C_TABLE_LAT      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [C_RPT_WIDTH-1:0]      num_repeat,
  input  logic                        stall,
  output logic [1:0]                  gray_code,
  output logic [C_SEQ_ADDR_WIDTH-1:0] seq_data_addr,
  output logic                        seq_issue,
  output logic                        wht_addr_valid,
  output logic                        busy,
  output logic                        done
);

  // state  | meaning
  // IDLE   | waiting for start
  // RUN    | issuing lookups, one per unstalled cycle
  // DRAIN  | last lookup issued, waiting for the valid delay line to empty
  // DONE   | one-cycle completion pulse
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [C_SEQ_ADDR_WIDTH-1:0] LAST_ADDR = C_SEQ_ADDR_WIDTH'(C_SEQ_LEN - 1);
  localparam logic [C_RPT_WIDTH-1:0]      RPT_ONE   = C_RPT_WIDTH'(1);

  state_t                 state;
  logic [C_RPT_WIDTH-1:0] rpt_cnt;
  logic [C_TABLE_LAT-1:0] vld_dly;

  // Phase order 00 -> 01 -> 11 -> 10 -> 00; only one bit flips per step.
  function automatic logic [1:0] gray_next(input logic [1:0] g);
    logic [1:0] n;
    n = 2'b00;
    case (g)
      2'b00:   n = 2'b01;
      2'b01:   n = 2'b11;
      2'b11:   n = 2'b10;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  // An issue is the current address pair in RUN during an unstalled cycle;
  // it must drop in the same cycle stall rises, so it is decoded from state.
  assign seq_issue      = (state == S_RUN) && !stall;
  assign wht_addr_valid = vld_dly[C_TABLE_LAT-1];

  // Valid delay line matching the table's registered lookup latency.
  generate
    if (C_TABLE_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_dly <= '0;
        else     vld_dly <= seq_issue;
      end
    end else begin : g_latn
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_dly <= '0;
        else     vld_dly <= {vld_dly[C_TABLE_LAT-2:0], seq_issue};
      end
    end
  endgenerate

  // Sequencing FSM: address walk, repeat count and busy/done handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      gray_code     <= 2'b00;
      seq_data_addr <= '0;
      rpt_cnt       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            gray_code     <= 2'b00;
            seq_data_addr <= '0;
            if (num_repeat != '0) begin
              rpt_cnt <= num_repeat;
              busy    <= 1'b1;
              state   <= S_RUN;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (seq_data_addr != LAST_ADDR) begin
              seq_data_addr <= seq_data_addr + 1'b1;
            end else begin
              seq_data_addr <= '0;
              gray_code     <= gray_next(gray_code);
              if (gray_code == 2'b10) begin
                rpt_cnt <= rpt_cnt - 1'b1;
                if (rpt_cnt == RPT_ONE) state <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          // Stall is deliberately ignored here: the table keeps returning data.
          if (vld_dly == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_weight_sequence_gen.sv
module tb_cnn_layer_accel_weight_sequence_gen;

  localparam int LEN = 5;
  localparam int AW  = 3;
  localparam int RW  = 8;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [RW-1:0] num_repeat = '0;
  logic          stall = 1'b0;
  logic [1:0]    gray_code;
  logic [AW-1:0] seq_data_addr;
  logic          seq_issue;
  logic          wht_addr_valid;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  cnn_layer_accel_weight_sequence_gen #(
    .C_SEQ_LEN(LEN), .C_SEQ_ADDR_WIDTH(AW), .C_RPT_WIDTH(RW), .C_TABLE_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_repeat(num_repeat), .stall(stall),
    .gray_code(gray_code), .seq_data_addr(seq_data_addr), .seq_issue(seq_issue),
    .wht_addr_valid(wht_addr_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gray"},  32'(gray_code), 0);
    chk({tag, "_addr"},  32'(seq_data_addr), 0);
    chk({tag, "_issue"}, 32'(seq_issue), 0);
    chk({tag, "_valid"}, 32'(wht_addr_valid), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
  endtask

  // One command. The model knows only the rules: the expected lookup list is
  // nr x (phases 00,01,11,10) x (entries 0..LEN-1); an issue happens in every
  // unstalled cycle after start while lookups remain; done comes LAT+2 cycles
  // after the last issue (or 1 cycle after start for nr=0).
  task automatic run_cmd(input int nr, input int s_lo, input int s_hi, input int pct,
                         input bit extra, input int rst_at);
    logic [1:0] ph [4];
    logic [4:0] q [$];
    logic [4:0] want;
    int remaining, issued, last_iss, exp_done, cyc, dones;
    bit st, exp_iss, prev_exp;
    ph[0] = 2'b00; ph[1] = 2'b01; ph[2] = 2'b11; ph[3] = 2'b10;
    for (int r = 0; r < nr; r++)
      for (int p = 0; p < 4; p++)
        for (int a = 0; a < LEN; a++)
          q.push_back({ph[p], 3'(a)});
    remaining = nr * 4 * LEN;
    issued    = 0;
    last_iss  = -1;
    exp_done  = (nr == 0) ? 1 : 100000;
    dones     = 0;
    prev_exp  = 1'b0;

    @(negedge clk);
    start = 1'b1; num_repeat = RW'(nr); stall = 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_issue", 32'(seq_issue), 0);

    for (cyc = 1; cyc <= 3000 && cyc <= exp_done + 1; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (rst_at >= 0 && issued == rst_at) begin
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all_zero("postrst");
        repeat (3) begin
          @(negedge clk);
          #1;
          chk("postrst_no_done", 32'(done), 0);
          chk("postrst_no_busy", 32'(busy), 0);
        end
        return;
      end
      if (extra && (issued == 5 || cyc == last_iss + 1 || cyc == exp_done)) begin
        start = 1'b1;
        num_repeat = RW'($urandom_range(1, 255));
      end
      st = ((cyc >= s_lo) && (cyc <= s_hi)) || (pct > 0 && $urandom_range(99) < pct);
      stall = st;
      #1;
      exp_iss = (remaining > 0) && !st;
      chk("issue", 32'(seq_issue), 32'(exp_iss));
      chk("valid", 32'(wht_addr_valid), 32'(prev_exp));
      if (exp_iss) begin
        want = q.pop_front();
        chk("entry", 32'({gray_code, seq_data_addr}), 32'(want));
        remaining--;
        issued++;
        if (remaining == 0) begin
          last_iss = cyc;
          exp_done = cyc + LAT + 2;
        end
      end
      if (done === 1'b1) dones++;
      chk("done", 32'(done), 32'(cyc == exp_done));
      chk("busy", 32'(busy), 32'(nr != 0 && cyc < exp_done));
      prev_exp = exp_iss;
    end
    stall = 1'b0;
    if (cyc > 3000) chk("timeout", 32'(cyc), 3000);
    chk("issues_left", 32'(q.size()), 0);
    chk("done_count", 32'(dones), 1);
    #1;
    chk("end_gray", 32'(gray_code), 0);
    chk("end_addr", 32'(seq_data_addr), 0);
  endtask

  initial begin
    #1;
    chk_all_zero("reset");
    #12;
    rst = 1'b0;
    // single walk, unstalled: done 23 cycles after start
    run_cmd(1, 0, -1, 0, 1'b0, -1);
    // three walks back to back
    run_cmd(3, 0, -1, 0, 1'b0, -1);
    // stall in cycles 7..9 after start
    run_cmd(1, 7, 9, 0, 1'b0, -1);
    // zero repeat count goes straight to done
    run_cmd(0, 0, -1, 0, 1'b0, -1);
    // stray starts during RUN, DRAIN and DONE are ignored
    run_cmd(1, 0, -1, 0, 1'b1, -1);
    // reset after 12 issues aborts, then a clean walk
    run_cmd(1, 0, -1, 0, 1'b0, 12);
    run_cmd(1, 0, -1, 0, 1'b0, -1);
    // random repeat counts with random stalls
    for (int i = 0; i < 4; i++)
      run_cmd($urandom_range(1, 3), 0, -1, 30, 1'(i % 2), -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
